// File: rtl/cfg_arb_pkg.sv
// cfg_arb_pkg: shared state encoding and constants for the cfg bus arbiter
package cfg_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} arb_state_t;
  localparam logic [31:0] CFG_ARB_DEADBEEF = 32'hdead_beef;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning upward from ptr with wrap
module rr_arbiter #(
  parameter int N = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] k;
  // Scan from farthest to nearest so the requester closest to ptr wins last
  always_comb begin
    gnt = '0;
    idx = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % N);
      if (req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        idx = k;
      end
    end
  end
endmodule

// File: rtl/cfg_bus_arb.sv
// cfg_bus_arb: round-robin sharing of one cfg bus among NUM_REQ masters; CFG_ARB_TIMEOUT_EN adds an ack watchdog
module cfg_bus_arb import cfg_arb_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  clk,
  input  logic                  sync_rst_n,
  input  logic                  sh_cl_flr_assert_q,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [31:0]           cfg_addr,
  output logic [31:0]           cfg_wdata,
  output logic                  cfg_wr,
  output logic                  cfg_rd,
  input  logic                  cfg_ack,
  input  logic [31:0]           cfg_rdata
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, owner, win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic wr_q, flr, busy, accept, ack_take, tmo, rsp_done;
  logic sel_wr;
  logic [31:0] sel_addr, sel_wdata;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(win_gnt),
    .idx(win_idx)
  );
  assign flr = sh_cl_flr_assert_q;
  assign busy = (state == ISSUE) || (state == WAIT_ACK);
  assign accept = sync_rst_n && !flr && (state == IDLE) && (|req_valid);
  assign ack_take = busy && !flr && cfg_ack;
  assign rsp_done = (state == RESP) && !flr && rsp_ready[owner];
  assign req_ready = accept ? win_gnt : '0;
  assign rsp_valid = (state == RESP) ? NUM_REQ'(1) << owner : '0;
  assign cfg_wr = (state == ISSUE) && !flr && wr_q;
  assign cfg_rd = (state == ISSUE) && !flr && !wr_q;
  always_comb begin
    sel_wr = 1'b0;
    sel_addr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win_gnt[i]) begin
        sel_wr = req_wr[i];
        sel_addr = req_addr[32*i +: 32];
        sel_wdata = req_wdata[32*i +: 32];
      end
  end
`ifdef CFG_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  // Counter is zeroed at accept so it reads 0 in the ISSUE cycle
  always_ff @(posedge clk) begin
    if (!sync_rst_n || accept) tmo_cnt <= '0;
    else if (busy) tmo_cnt <= tmo_cnt + 16'd1;
  end
  assign tmo = busy && !cfg_ack && (tmo_cnt == 16'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_nxt = flr ? IDLE
              : (state == IDLE) ? (accept ? ISSUE : IDLE)
              : busy ? ((cfg_ack || tmo) ? RESP : WAIT_ACK)
              : (rsp_ready[owner] ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      wr_q <= 1'b0;
      cfg_addr <= '0;
      cfg_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner <= win_idx;
        wr_q <= sel_wr;
        cfg_addr <= sel_addr;
        cfg_wdata <= sel_wdata;
      end
      if (ack_take) begin
        rsp_rdata <= cfg_rdata;
        rsp_err <= 1'b0;
      end else if (tmo && !flr) begin
        rsp_rdata <= CFG_ARB_DEADBEEF;
        rsp_err <= 1'b1;
      end
      if (rsp_done) rr_ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    end
  end
endmodule
